// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register-file word, register selector and the
// write-port arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic {
    ARB_A     = 1'b0,
    ARB_FORCE = 1'b1
  } arb_state_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one flag per register with an outstanding B write.
// Register 0 is never tracked; a set and clear on the same bit resolve to set.
module rf_scoreboard
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       set_en,
  input  logic [4:0] set_sel,
  input  logic       clr_en,
  input  logic [4:0] clr_sel,
  output logic [31:0] busy
);

  word_t busy_reg;
  word_t busy_next;

  assign busy_next[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_en && (set_sel == regbits_t'(gi));
      assign clr_hit = clr_en && (clr_sel == regbits_t'(gi));
      assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
    end
  endgenerate

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback (A)
// and a long-latency unit (B). Optional scoreboard under RF_WARB_SCOREBOARD_EN.
module rf_write_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_wsel,
  input  logic [31:0] a_wdat,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_wsel,
  input  logic [31:0] b_wdat,
  input  logic        b_issue,
  input  logic [4:0]  b_issue_sel,
  output logic        rf_WEN,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic [31:0] busy
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_t                state_reg;
  logic [STARVE_CNT_W-1:0]   starve_reg;
  logic [STARVE_CNT_W-1:0]   starve_next;
  logic                      force_next;
  logic                      collision;
  logic                      a_fire;
  logic                      b_fire;
  logic                      rf_wen_reg;
  regbits_t                  rf_wsel_reg;
  word_t                     rf_wdat_reg;

  // Same nonzero destination: A is younger, so B can retire silently alongside it.
  always_comb begin
    collision = a_valid && b_valid && (a_wsel == b_wsel) && (a_wsel != 5'd0);
    a_ready   = (state_reg == ARB_A);
    b_ready   = (state_reg == ARB_FORCE) || !a_valid || collision;
    a_fire    = a_valid && a_ready;
    b_fire    = b_valid && b_ready;
  end

  always_comb begin
    starve_next = starve_reg;
    if (!b_valid || b_fire) begin
      starve_next = '0;
    end else if (starve_reg < LIMIT) begin
      starve_next = starve_reg + 1'b1;
    end
    force_next = (state_reg == ARB_A) && b_valid && !b_fire && (starve_next == LIMIT);
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_reg   <= ARB_A;
      starve_reg  <= '0;
      rf_wen_reg  <= 1'b0;
      rf_wsel_reg <= '0;
      rf_wdat_reg <= '0;
    end else begin
      starve_reg <= starve_next;
      state_reg  <= force_next ? ARB_FORCE : ARB_A;
      // A wins the port whenever it fires; on a collision B's data is discarded.
      if (a_fire) begin
        rf_wen_reg  <= (a_wsel != 5'd0);
        rf_wsel_reg <= a_wsel;
        rf_wdat_reg <= a_wdat;
      end else if (b_fire) begin
        rf_wen_reg  <= (b_wsel != 5'd0);
        rf_wsel_reg <= b_wsel;
        rf_wdat_reg <= b_wdat;
      end else begin
        rf_wen_reg  <= 1'b0;
      end
    end
  end

  assign rf_WEN  = rf_wen_reg;
  assign rf_wsel = rf_wsel_reg;
  assign rf_wdat = rf_wdat_reg;

`ifdef RF_WARB_SCOREBOARD_EN
  rf_scoreboard u_scoreboard (
    .CLK     (CLK),
    .nRST    (nRST),
    .set_en  (b_issue && (b_issue_sel != 5'd0)),
    .set_sel (b_issue_sel),
    .clr_en  (b_fire),
    .clr_sel (b_wsel),
    .busy    (busy)
  );
`else
  logic unused_issue;
  assign unused_issue = ^{b_issue, b_issue_sel};
  assign busy = '0;
`endif

endmodule
